// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares one DDR read port among REQ_N burst loaders.
// Ports: req_* (per-requester burst requests), ddr_cmd_* (DDR read
// command), ddr_rd_* (DDR read data), rd_* (routed beats to the
// granted requester), busy. Clocked on clk with sync active-high rst.
// Macro DDR_RD_ARB_RR_EN selects round-robin; default is fixed priority.
module ddr_rd_arbiter #(
  parameter int REQ_N      = 4,
  parameter int DDR_W      = 256,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_N-1:0]            req_valid,
  output logic [REQ_N-1:0]            req_ready,
  input  logic [REQ_N*DDR_ADDR_W-1:0] req_addr,
  input  logic [REQ_N*BURST_W-1:0]    req_len,
  output logic                        ddr_cmd_valid,
  input  logic                        ddr_cmd_ready,
  output logic [DDR_ADDR_W-1:0]       ddr_cmd_addr,
  output logic [BURST_W-1:0]          ddr_cmd_len,
  input  logic                        ddr_rd_valid,
  output logic                        ddr_rd_ready,
  input  logic [DDR_W-1:0]            ddr_rd_data,
  output logic [REQ_N-1:0]            rd_valid,
  input  logic [REQ_N-1:0]            rd_ready,
  output logic [DDR_W-1:0]            rd_data,
  output logic                        rd_last,
  output logic                        busy
);

  localparam int GW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [GW-1:0]         r_gnt;
  logic [GW-1:0]         w_gnt;
  logic                  w_any;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic [BURST_W-1:0]    r_len;
  logic [BURST_W-1:0]    r_beat_cnt;
  logic [DDR_ADDR_W-1:0] w_sel_addr;
  logic [BURST_W-1:0]    w_sel_len;
  logic                  w_accept;
  logic                  w_beat;

`ifdef DDR_RD_ARB_RR_EN
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        w_start;
  logic [2*REQ_N-1:0]   w_dbl;
  logic [REQ_N-1:0]     w_rot;

  // Rotate the request vector so the search starts just after the
  // last winner; the first set bit of the rotated vector wins.
  assign w_start = (r_ptr == GW'(REQ_N-1)) ? '0 : r_ptr + 1'b1;
  assign w_dbl   = {req_valid, req_valid} >> w_start;
  assign w_rot   = w_dbl[REQ_N-1:0];

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!w_any && w_rot[i]) begin
        w_any = 1'b1;
        w_gnt = GW'((int'(w_start) + i) % REQ_N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= GW'(REQ_N-1);
    end else if (w_accept) begin
      r_ptr <= w_gnt;
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!w_any && req_valid[i]) begin
        w_any = 1'b1;
        w_gnt = GW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (w_gnt == GW'(i)) begin
        w_sel_addr = req_addr[i*DDR_ADDR_W +: DDR_ADDR_W];
        w_sel_len  = req_len[i*BURST_W +: BURST_W];
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    ddr_cmd_valid = 1'b0;
    ddr_rd_ready  = 1'b0;
    rd_valid      = '0;
    rd_last       = 1'b0;
    w_accept      = 1'b0;
    w_beat        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready = REQ_N'(1) << w_gnt;
          w_accept  = 1'b1;
          // Zero-length requests are consumed without a command.
          if (w_sel_len != '0) w_next = S_CMD;
        end
      end
      S_CMD: begin
        ddr_cmd_valid = 1'b1;
        if (ddr_cmd_ready) w_next = S_DATA;
      end
      S_DATA: begin
        rd_valid = {REQ_N{ddr_rd_valid}} & (REQ_N'(1) << r_gnt);
        ddr_rd_ready = rd_ready[r_gnt];
        rd_last = (r_beat_cnt == r_len - 1'b1) && ddr_rd_valid;
        w_beat  = ddr_rd_valid && ddr_rd_ready;
        if (w_beat && rd_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt  <= w_gnt;
        r_addr <= w_sel_addr;
        r_len  <= w_sel_len;
      end
      if (r_state == S_CMD && ddr_cmd_ready) begin
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign ddr_cmd_addr = r_addr;
  assign ddr_cmd_len  = r_len;
  assign rd_data      = ddr_rd_data;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Testbench for ddr_rd_arbiter: scenario tasks with a beat scoreboard.
// Honours DDR_RD_ARB_RR_EN for the expected grant order.
module tb_ddr_rd_arbiter;

  localparam int REQ_N = 4;
  localparam int DW    = 256;
  localparam int AW    = 32;
  localparam int BW    = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [REQ_N-1:0]   req_valid;
  logic [REQ_N-1:0]   req_ready;
  logic [REQ_N*AW-1:0] req_addr;
  logic [REQ_N*BW-1:0] req_len;
  logic               ddr_cmd_valid;
  logic               ddr_cmd_ready;
  logic [AW-1:0]      ddr_cmd_addr;
  logic [BW-1:0]      ddr_cmd_len;
  logic               ddr_rd_valid;
  logic               ddr_rd_ready;
  logic [DW-1:0]      ddr_rd_data;
  logic [REQ_N-1:0]   rd_valid;
  logic [REQ_N-1:0]   rd_ready;
  logic [DW-1:0]      rd_data;
  logic               rd_last;
  logic               busy;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(
    .REQ_N(REQ_N), .DDR_W(DW), .DDR_ADDR_W(AW), .BURST_W(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready),
    .ddr_cmd_addr(ddr_cmd_addr), .ddr_cmd_len(ddr_cmd_len),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_ready(ddr_rd_ready),
    .ddr_rd_data(ddr_rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [BW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*BW +: BW]  = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Acts as the DDR data source; starts at a negedge while in DATA and
  // returns at the negedge following the last beat.
  task automatic serve_data(input int g, input int len, input bit bp);
    int beats = 0;
    int cyc = 0;
    logic want;
    logic [DW-1:0] d;
    beat_t e;
    logic [REQ_N-1:0] oh;
    oh = REQ_N'(1) << g;
    while (beats < len && cyc < 200) begin
      d = {8{$urandom}};
      want = bp ? (cyc % 2 == 0) : 1'b1;
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = d;
      rd_ready = (REQ_N'($urandom) & ~oh) | (want ? oh : '0);
      if (want) begin
        e.idx = g; e.data = d; e.last = (beats == len - 1);
        sb.push_back(e);
      end
      #1;
      n_checks++;
      if (rd_valid !== oh) begin
        n_fail++;
        $display("FAIL rd_valid beat%0d: got %b want %b",
                 beats, rd_valid, oh);
      end
      n_checks++;
      if (ddr_rd_ready !== want) begin
        n_fail++;
        $display("FAIL ddr_rd_ready cyc%0d: got %b want %b",
                 cyc, ddr_rd_ready, want);
      end
      n_checks++;
      if (rd_last !== (beats == len - 1)) begin
        n_fail++;
        $display("FAIL rd_last beat%0d: got %b want %b",
                 beats, rd_last, (beats == len - 1));
      end
      if (rd_valid[g] && ddr_rd_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: got beat, want none");
        end else begin
          e = sb.pop_front();
          if (rd_data !== e.data || rd_last !== e.last ||
              !rd_valid[e.idx]) begin
            n_fail++;
            $display("FAIL sb_beat%0d: got last=%b data=%h want last=%b data=%h",
                     beats, rd_last, rd_data, e.last, e.data);
          end
        end
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    ddr_rd_valid = 1'b0;
    rd_ready = '0;
    #1;
    n_checks++;
    if (beats != len) begin
      n_fail++;
      $display("FAIL beat_count: got %0d want %0d", beats, len);
    end
    n_checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL end_of_burst: got busy=%b sb=%0d want busy=0 sb=0",
               busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0;
    ddr_cmd_ready = 1'b1; ddr_rd_valid = 1'b1;
    ddr_rd_data = '0; rd_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || ddr_cmd_valid !== 1'b0 || ddr_cmd_addr !== '0 ||
        ddr_cmd_len !== '0 || req_ready !== '0 || rd_valid !== '0 ||
        ddr_rd_ready !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b cv=%b ca=%h cl=%h rr=%b rv=%b dr=%b rl=%b want all 0",
               busy, ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len,
               req_ready, rd_valid, ddr_rd_ready, rd_last);
    end
    ddr_rd_valid = 1'b0;
    rd_ready = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(1, 32'h1000, 16'd4);
    req_valid = 4'b0010;
    ddr_cmd_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_req_ready: got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++;
    if (ddr_cmd_valid !== 1'b1 || ddr_cmd_addr !== 32'h1000 ||
        ddr_cmd_len !== 16'd4 || req_ready !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cmd: got v=%b a=%h l=%0d rr=%b want v=1 a=1000 l=4 rr=0",
               ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len, req_ready);
    end
    @(negedge clk);
    serve_data(1, 4, 1'b0);
  endtask

  task automatic test_arbitration();
    int exp_g;
    do_reset();
    for (int i = 0; i < REQ_N; i++) set_req(i, AW'(32'h100 * (i + 1)), 16'd2);
    req_valid = '1;
    ddr_cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef DDR_RD_ARB_RR_EN
      exp_g = k % REQ_N;
`else
      exp_g = 0;
`endif
      #1;
      n_checks++;
      if (req_ready !== (REQ_N'(1) << exp_g)) begin
        n_fail++;
        $display("FAIL arb_grant%0d: got %b want %b",
                 k, req_ready, REQ_N'(1) << exp_g);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (ddr_cmd_addr !== AW'(32'h100 * (exp_g + 1))) begin
        n_fail++;
        $display("FAIL arb_addr%0d: got %h want %h",
                 k, ddr_cmd_addr, 32'h100 * (exp_g + 1));
      end
      @(negedge clk);
      serve_data(exp_g, 2, 1'b0);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(2, 32'h2000, 16'd8);
    req_valid = 4'b0100;
    ddr_cmd_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    serve_data(2, 8, 1'b1);
  endtask

  task automatic test_cmd_stall();
    @(negedge clk);
    set_req(0, 32'hCAFE_0040, 16'd3);
    req_valid = 4'b0001;
    ddr_cmd_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    set_req(0, 32'h0BAD_0000, 16'd9);
    ddr_rd_valid = 1'b1;
    rd_ready = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (ddr_cmd_valid !== 1'b1 || ddr_cmd_addr !== 32'hCAFE_0040 ||
          ddr_cmd_len !== 16'd3 || ddr_rd_ready !== 1'b0 ||
          rd_valid !== '0) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b a=%h l=%0d dr=%b rv=%b want v=1 a=cafe0040 l=3 dr=0 rv=0",
                 c, ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len,
                 ddr_rd_ready, rd_valid);
      end
      @(negedge clk);
    end
    ddr_rd_valid = 1'b0;
    rd_ready = '0;
    ddr_cmd_ready = 1'b1;
    #1;
    n_checks++;
    if (ddr_cmd_valid !== 1'b1 || ddr_rd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b dr=%b want v=1 dr=0",
               ddr_cmd_valid, ddr_rd_ready);
    end
    @(negedge clk);
    ddr_cmd_ready = 1'b0;
    serve_data(0, 3, 1'b0);
    ddr_cmd_ready = 1'b1;
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    set_req(2, 32'h3000, 16'd0);
    set_req(3, 32'h4000, 16'd1);
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL len0_ready: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    n_checks++;
    if (ddr_cmd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL len0_next: got cv=%b busy=%b rr=%b want cv=0 busy=0 rr=1000",
               ddr_cmd_valid, busy, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++;
    if (ddr_cmd_valid !== 1'b1 || ddr_cmd_addr !== 32'h4000 ||
        ddr_cmd_len !== 16'd1) begin
      n_fail++;
      $display("FAIL len0_cmd: got v=%b a=%h l=%0d want v=1 a=4000 l=1",
               ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len);
    end
    @(negedge clk);
    serve_data(3, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, 32'h5000, 16'd16);
    set_req(0, 32'h6000, 16'd2);
    req_valid = 4'b0010;
    ddr_cmd_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data = {8{$urandom}};
      rd_ready = '1;
      #1;
      n_checks++;
      if (rd_valid !== 4'b0010 || rd_last !== 1'b0 ||
          rd_data !== ddr_rd_data) begin
        n_fail++;
        $display("FAIL mid_beat%0d: got rv=%b rl=%b want rv=0010 rl=0",
                 b, rd_valid, rd_last);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || ddr_cmd_valid !== 1'b0 || ddr_cmd_addr !== '0 ||
        ddr_cmd_len !== '0 || rd_valid !== '0 || ddr_rd_ready !== 1'b0 ||
        rd_last !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b cv=%b ca=%h cl=%h rv=%b dr=%b rl=%b rr=%b want 0s and rr=0001",
               busy, ddr_cmd_valid, ddr_cmd_addr, ddr_cmd_len,
               rd_valid, ddr_rd_ready, rd_last, req_ready);
    end
    req_valid = '0;
    ddr_rd_valid = 1'b0;
    rd_ready = '0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_cmd_stall();
    test_len_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
